// File: rtl/wavegen_pkg.sv
// Shared definitions for the NCO waveform generator: mode encodings and noise LFSR constants.
package wavegen_pkg;

    typedef enum logic [2:0] {
        MODE_SQUARE = 3'd0,
        MODE_SAW    = 3'd1,
        MODE_RSAW   = 3'd2,
        MODE_TRI    = 3'd3,
        MODE_PWM    = 3'd4,
        MODE_NOISE  = 3'd5,
        MODE_SINE   = 3'd6,
        MODE_ZERO   = 3'd7
    } mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps at bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/wavegen_sine_rom.sv
// Quarter-wave sine table with quadrant mirroring; offset-binary output.
// Only compiled when WAVEGEN_SINE_EN is defined; requires WIDTH >= 3.
`ifdef WAVEGEN_SINE_EN
module wavegen_sine_rom #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_phase,
    output logic [WIDTH-1:0] o_sample
);

    localparam int unsigned AW  = WIDTH - 2;
    localparam int unsigned N   = 1 << AW;
    localparam longint      AMP = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
    localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

    // Elaboration-time Q30 Taylor series of sin(idx/N * pi/2), scaled to AMP
    function automatic logic [WIDTH-2:0] quarter_sin(input int unsigned idx);
        longint x, x2, term, acc, v;
        x    = (longint'(idx) * 64'sd1686629713) / longint'(N);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int unsigned k = 1; k < 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        v = (acc * AMP + (64'sd1 <<< 29)) >>> 30;
        if (v < 0)   v = 0;
        if (v > AMP) v = AMP;
        return v[WIDTH-2:0];
    endfunction

    logic [WIDTH-2:0] w_rom [N];
    logic [1:0]       w_quad;
    logic [AW-1:0]    w_idx;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-2:0] w_mag;

    for (genvar gi = 0; gi < N; gi++) begin : g_rom
        assign w_rom[gi] = quarter_sin(gi);
    end

    assign w_quad = i_phase[WIDTH-1 -: 2];
    assign w_idx  = i_phase[AW-1:0];
    assign w_addr = w_quad[0] ? ~w_idx : w_idx;
    assign w_mag  = w_rom[w_addr];

    always_comb begin
        o_sample = MID;
        if (w_quad[1]) o_sample = MID - {1'b0, w_mag};
        else           o_sample = MID + {1'b0, w_mag};
    end

endmodule
`endif

// File: rtl/wavegen_nco.sv
// NCO-driven multi-mode waveform generator, one channel. Mode 6 is a sine
// when WAVEGEN_SINE_EN is defined, otherwise constant 0 like mode 7.
module wavegen_nco
    import wavegen_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2:0]         select,
    input  logic [PHASE_W-1:0] step,
    input  logic [WIDTH-1:0]   duty,
    output logic [WIDTH-1:0]   out,
    output logic               wrap
);

    logic [PHASE_W-1:0] r_phase;
    mode_e              r_sel;
    logic [WIDTH-1:0]   r_out;
    logic               r_wrap;
    logic [15:0]        r_lfsr;

    logic [PHASE_W-1:0] w_phase_n;
    mode_e              w_sel_n;
    logic [WIDTH-1:0]   w_out_n;
    logic               w_wrap_n;
    logic [15:0]        w_lfsr_n;
    logic [PHASE_W:0]   w_sum;
    mode_e              w_sel_in;
    logic [WIDTH-1:0]   w_sine;

`ifdef WAVEGEN_SINE_EN
    localparam logic [WIDTH-1:0] SINE_AT_ZERO = {1'b1, {(WIDTH-1){1'b0}}};

    wavegen_sine_rom #(
        .WIDTH(WIDTH)
    ) u_sine (
        .i_phase (r_phase[PHASE_W-1 -: WIDTH]),
        .o_sample(w_sine)
    );
`else
    localparam logic [WIDTH-1:0] SINE_AT_ZERO = '0;

    assign w_sine = '0;
`endif

    // top = phase[PHASE_W-1 -: WIDTH+1]: p is its upper WIDTH bits, q its lower WIDTH bits
    function automatic logic [WIDTH-1:0] sample_fn(
        input mode_e            m,
        input logic [WIDTH:0]   top,
        input logic [WIDTH-1:0] noise,
        input logic [WIDTH-1:0] dty,
        input logic [WIDTH-1:0] sine_v
    );
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] q;
        logic             msb;
        p   = top[WIDTH:1];
        q   = top[WIDTH-1:0];
        msb = top[WIDTH];
        case (m)
            MODE_SQUARE: return msb ? '1 : '0;
            MODE_SAW:    return p;
            MODE_RSAW:   return ~p;
            MODE_TRI:    return msb ? ~q : q;
            MODE_PWM:    return (p < dty) ? '1 : '0;
            MODE_NOISE:  return noise;
            MODE_SINE:   return sine_v;
            default:     return '0;
        endcase
    endfunction

    assign w_sel_in = mode_e'(select);
    assign w_sum    = {1'b0, r_phase} + {1'b0, step};

    always_comb begin
        w_phase_n = r_phase;
        w_sel_n   = r_sel;
        w_out_n   = r_out;
        w_wrap_n  = 1'b0;
        w_lfsr_n  = r_lfsr;
        if (w_sel_in != r_sel) begin
            // Mode change wins over en and restarts the waveform at phase 0
            w_sel_n   = w_sel_in;
            w_phase_n = '0;
            w_out_n   = sample_fn(w_sel_in, '0, r_lfsr[WIDTH-1:0], duty, SINE_AT_ZERO);
        end else if (en) begin
            w_phase_n = w_sum[PHASE_W-1:0];
            w_out_n   = sample_fn(r_sel, r_phase[PHASE_W-1 -: WIDTH+1],
                                  r_lfsr[WIDTH-1:0], duty, w_sine);
            w_wrap_n  = w_sum[PHASE_W];
            if (w_sum[PHASE_W]) w_lfsr_n = lfsr_next(r_lfsr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase <= '0;
            r_sel   <= MODE_SQUARE;
            r_out   <= '0;
            r_wrap  <= 1'b0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_phase <= w_phase_n;
            r_sel   <= w_sel_n;
            r_out   <= w_out_n;
            r_wrap  <= w_wrap_n;
            r_lfsr  <= w_lfsr_n;
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_wavegen_nco.sv
// Directed self-checking bench for wavegen_nco (WIDTH=8, PHASE_W=16).
module tb_wavegen_nco;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  select;
    logic [15:0] step;
    logic [7:0]  duty;
    logic [7:0]  out;
    logic        wrap;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wavegen_nco #(
        .WIDTH  (8),
        .PHASE_W(16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .select(select),
        .step  (step),
        .duty  (duty),
        .out   (out),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned ones;
        logic [15:0] m;
        logic [31:0] e;

        rst = 1'b0; en = 1'b0; select = 3'd0; step = '0; duty = '0;
        tick(); tick();
        check("rst_out", 32'(out), 0);
        check("rst_wrap", 32'(wrap), 0);

        // Sawtooth: mode-change edge, then 0..255,0 with wrap on the 255 sample
        rst = 1'b1; en = 1'b1; select = 3'd1; step = 16'h0100;
        tick();
        check("saw_modechg", 32'(out), 0);
        check("saw_modechg_wrap", 32'(wrap), 0);
        for (int k = 0; k <= 256; k++) begin
            tick();
            check($sformatf("saw_out[%0d]", k), 32'(out), 32'(k % 256));
            check($sformatf("saw_wrap[%0d]", k), 32'(wrap), (k == 255) ? 1 : 0);
        end

        for (int k = 1; k <= 100; k++) tick();
        check("saw_at100", 32'(out), 100);

        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("freeze_out[%0d]", k), 32'(out), 100);
            check($sformatf("freeze_wrap[%0d]", k), 32'(wrap), 0);
        end
        en = 1'b1;
        tick();
        check("unfreeze_out", 32'(out), 101);

        // Switch to reverse sawtooth mid-ramp: phase restarts at 0
        select = 3'd2;
        tick();
        check("rsaw_modechg", 32'(out), 255);
        check("rsaw_modechg_wrap", 32'(wrap), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rsaw_out[%0d]", k), 32'(out), 32'(255 - k));
        end

        rst = 1'b0;
        tick();
        check("rst_prio_out", 32'(out), 0);
        check("rst_prio_wrap", 32'(wrap), 0);
        rst = 1'b1;

        select = 3'd3;
        tick();
        check("tri_modechg", 32'(out), 0);
        for (int k = 0; k < 256; k++) begin
            tick();
            e = (k < 128) ? 32'(2 * k) : 32'(511 - 2 * k);
            check($sformatf("tri_out[%0d]", k), 32'(out), e);
        end

        select = 3'd4; duty = 8'd64;
        tick();
        check("pwm_modechg", 32'(out), 255);
        ones = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            check($sformatf("pwm64_out[%0d]", k), 32'(out), (k < 64) ? 255 : 0);
            if (out == 8'd255) ones++;
        end
        check("pwm64_ones", ones, 64);

        duty = 8'd0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("pwm0_out[%0d]", k), 32'(out), 0);
        end

        duty = 8'd255;
        for (int j = 0; j < 256; j++) begin
            tick();
            e = (((20 + j) % 256) == 255) ? 0 : 255;
            check($sformatf("pwm255_out[%0d]", j), 32'(out), e);
        end

        // step=0 at p=20 with duty=255: static phase, constant high, no wrap
        step = 16'h0000;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("step0_out[%0d]", k), 32'(out), 255);
            check($sformatf("step0_wrap[%0d]", k), 32'(wrap), 0);
        end

        step = 16'h0100; select = 3'd7;
        tick();
        check("zero_modechg", 32'(out), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("zero_out[%0d]", k), 32'(out), 0);
        end

        select = 3'd6;
        tick();
`ifdef WAVEGEN_SINE_EN
        check("sine_modechg", 32'(out), 128);
`else
        check("sine_modechg", 32'(out), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("sine_off_out[%0d]", k), 32'(out), 0);
        end
`endif

        // Noise: reseed via reset, half-turn step -> carry every second edge
        rst = 1'b0;
        tick();
        rst = 1'b1; select = 3'd5; step = 16'h8000;
        m = 16'hACE1;
        tick();
        check("noise_modechg", 32'(out), 32'(m[7:0]));
        check("noise_modechg_wrap", 32'(wrap), 0);
        for (int n = 1; n <= 2000; n++) begin
            tick();
            check($sformatf("noise_out[%0d]", n), 32'(out), 32'(m[7:0]));
            check($sformatf("noise_wrap[%0d]", n), 32'(wrap), (n % 2 == 0) ? 1 : 0);
            if (n % 2 == 0) m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
